// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the PC, issues 1-cycle-latency word fetches and
// buffers returned {instr, pc} pairs in a DEPTH-entry FIFO toward decode.
`timescale 1ns/1ps
module fetch_queue #(
    parameter int unsigned      N        = 64,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [N-1:0]     RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [N-1:0]               imem_addr,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [N-1:0]               redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [N-1:0]               out_pc,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [31:0]  instr;
        logic [N-1:0] pc;
    } entry_t;

    entry_t         mem_q [DEPTH];
    logic [N-1:0]   pc_q, pc_d;
    logic [N-1:0]   inflight_pc_q, inflight_pc_d;
    logic           inflight_q, inflight_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW:0]    used;
    logic           push, pop;
    logic           unused_rpc_lo;

    assign unused_rpc_lo = ^redirect_pc[1:0];

    // Credit check counts the in-flight fetch so a returning word always has a slot.
    assign used      = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign imem_req  = reset & ~redirect & (used < (CW+1)'(DEPTH));
    assign imem_addr = pc_q;
    assign push      = inflight_q & ~redirect;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign out_instr = mem_q[rd_ptr_q].instr;
    assign out_pc    = mem_q[rd_ptr_q].pc;
    assign count     = count_q;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (redirect) begin
            pc_d     = {redirect_pc[N-1:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (imem_req) begin
                pc_d          = pc_q + N'(4);
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{instr: imem_rdata, pc: inflight_pc_q};
    end

    assert property (@(posedge clk) disable iff (!reset) !(push && count_q == CW'(DEPTH)));

endmodule
